rx_align_ctrl: RTL and testbench
================================

// Module: rx_align_ctrl
// PURPOSE
//  Word-alignment controller for the PHY receive path. Runs on clk_8f.
//  Hunts the serial stream for the comma byte and locks the byte phase after
//  LOCK_CNT consecutive aligned commas. While locked it emits one aligned word
//  per 8 bits, with a strobe and a valid flag, to the clk_f-domain parallel
//  stage. Drops lock after UNLOCK_CNT misaligned commas.
// PARAMETERS
//  COMMA       8'hBC  alignment / idle byte, MSB received first
//  LOCK_CNT    4      consecutive aligned commas needed to lock (2..7)
//  UNLOCK_CNT  3      misaligned commas, with no aligned comma between, that drop lock (1..7)
// PORTS
//  clk_8f     in   1  bit clock, rising edge; the only clock
//  reset_L    in   1  synchronous reset, active low
//  in         in   1  serial data, one bit per clk_8f, MSB first
//  enable     in   1  0 = sync clear to SEARCH, all outputs 0, counters 0
//  data_out   out  8  last aligned word, held between strobes
//  word_stb   out  1  1-cycle pulse per aligned word, LOCKED only
//  data_valid out  1  = word_stb & (data_out != COMMA)
//  is_comma   out  1  = word_stb & (data_out == COMMA)
//  locked     out  1  state == LOCKED
//  state      out  2  00 SEARCH, 01 CHECK, 10 LOCKED
// BEHAVIOUR
//  - Reset (reset_L=0 at posedge) or enable=0: sr, bit_cnt, comma_cnt and
//    miss_cnt go to 0; all outputs go to 0; state goes to SEARCH.
//    This applies mid-word and mid-lock, with no drain.
//  - sr_nxt = {sr[6:0], in}; sr <= sr_nxt every enabled cycle.
//  - Comparisons use sr_nxt, so the decision lands in the same cycle the
//    8th bit is sampled.
//  - bit_cnt is 3-bit and wraps 7->0. A "boundary" is a cycle with bit_cnt==7.
//  - SEARCH: if sr_nxt==COMMA, then bit_cnt<=0, comma_cnt<=1, go to CHECK.
//    Otherwise stay; bit_cnt is don't-care.
//  - CHECK: bit_cnt increments each cycle. At a boundary:
//    - sr_nxt==COMMA: comma_cnt+1; go to LOCKED when it reaches LOCK_CNT.
//      In that same cycle bit_cnt->0, with no strobe yet.
//    - otherwise: back to SEARCH, comma_cnt<=0.
//    - Non-boundary commas in CHECK are ignored.
//  - LOCKED: at each boundary, data_out<=sr_nxt and word_stb=1 for the next
//    cycle. Outputs are registered, so there is 1 clk_8f of latency after
//    the 8th bit.
//    - Aligned comma: miss_cnt<=0.
//    - Non-boundary cycle with sr_nxt==COMMA: miss_cnt+1.
//      - If it reaches UNLOCK_CNT: go to SEARCH with no strobe that cycle,
//        locked=0 next cycle, data_out holds, counters clear.
//    - A boundary word is never a misaligned hit.
//  - Misaligned comma and boundary in the same cycle cannot occur (they are
//    distinct bit positions).
//  - Counters saturate and never wrap: comma_cnt at LOCK_CNT, miss_cnt at
//    UNLOCK_CNT.
//  - Steady state: word_stb has exactly one pulse per 8 cycles; data_out is
//    stable for 8 cycles after each strobe.
// TESTING
//  1 Reset: hold reset_L=0 for 3 clk, random in -> all outputs 0, state=00.
//    Release and feed 8'h00 -> state stays 00.
//  2 Lock: 3 junk bits, then BC x4 -> state 00->01 on 1st BC.
//    - locked=1 after the 4th BC's last bit.
//    - Then BC,5A,A5 -> word_stb every 8 clk; data_out BC,5A,A5.
//    - valid only on 5A and A5; is_comma on BC.
//  3 CHECK fail: BC,BC,3C -> back to SEARCH at the 3C boundary.
//    - comma_cnt=0; no word_stb ever asserted.
//  4 Unlock: lock, then insert BC shifted by 3 bits, 3 times, with data
//    between and no aligned BC -> locked falls after the 3rd.
//    - With an aligned BC between the 2nd and 3rd -> stays locked.
//  5 Mid-op reset/enable: while locked, pulse enable=0 for 1 clk mid-word
//    -> state=00 and outputs 0 next cycle.
//    - Relock needs 4 new BC; same check with reset_L=0.
//  6 Rx sweep: for each bit offset 0..7, lock and send 16 random bytes ->
//    data_out sequence matches TX, one strobe per 8 clk.

Source files
------------

// File: rtl/rx_align_ctrl_if.sv
// Parallel-side signal bundle of the receive word aligner.
// The master side drives the serial bit and enable; the slave side returns aligned words and status.
interface rx_align_ctrl_if;
    logic       in;
    logic       enable;
    logic [7:0] data_out;
    logic       word_stb;
    logic       data_valid;
    logic       is_comma;
    logic       locked;
    logic [1:0] state;

    modport master (
        output in, enable,
        input  data_out, word_stb, data_valid, is_comma, locked, state
    );
    modport slave (
        input  in, enable,
        output data_out, word_stb, data_valid, is_comma, locked, state
    );
endinterface

// File: rtl/rx_align_ctrl.sv
// Serial word aligner: hunts for the comma byte, locks the byte phase after LOCK_CNT aligned
// commas, then emits one registered word per 8 bit clocks until UNLOCK_CNT misaligned commas.
module rx_align_ctrl #(
    parameter logic [7:0]  COMMA      = 8'hBC,
    parameter int unsigned LOCK_CNT   = 4,
    parameter int unsigned UNLOCK_CNT = 3
) (
    input logic            clk_8f,
    input logic            reset_L,
    rx_align_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        SEARCH = 2'b00,
        CHECK  = 2'b01,
        LOCKED = 2'b10
    } state_e;

    localparam logic [2:0] LOCK_C   = 3'(LOCK_CNT);
    localparam logic [2:0] UNLOCK_C = 3'(UNLOCK_CNT);

    state_e     state_q, state_d;
    logic [6:0] sr_q, sr_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [2:0] comma_cnt_q, comma_cnt_d;
    logic [2:0] miss_cnt_q, miss_cnt_d;
    logic [7:0] data_out_q, data_out_d;
    logic       word_stb_q, word_stb_d;

    logic [7:0] sr_nxt;
    logic       hit;
    logic       boundary;
    logic [2:0] comma_inc;
    logic [2:0] miss_inc;

    // Decisions look at the byte including the bit arriving this cycle.
    assign sr_nxt    = {sr_q, bus.in};
    assign hit       = (sr_nxt == COMMA);
    assign boundary  = (bit_cnt_q == 3'd7);
    assign comma_inc = (comma_cnt_q == LOCK_C)   ? comma_cnt_q : comma_cnt_q + 3'd1;
    assign miss_inc  = (miss_cnt_q  == UNLOCK_C) ? miss_cnt_q  : miss_cnt_q  + 3'd1;

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_nxt[6:0];
        bit_cnt_d   = bit_cnt_q + 3'd1;
        comma_cnt_d = comma_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        data_out_d  = data_out_q;
        word_stb_d  = 1'b0;

        if (!bus.enable) begin
            state_d     = SEARCH;
            sr_d        = '0;
            bit_cnt_d   = '0;
            comma_cnt_d = '0;
            miss_cnt_d  = '0;
            data_out_d  = '0;
        end else begin
            unique case (state_q)
                SEARCH: begin
                    if (hit) begin
                        bit_cnt_d   = '0;
                        comma_cnt_d = 3'd1;
                        state_d     = CHECK;
                    end
                end
                CHECK: begin
                    if (boundary) begin
                        if (hit) begin
                            comma_cnt_d = comma_inc;
                            if (comma_inc >= LOCK_C) begin
                                state_d    = LOCKED;
                                miss_cnt_d = '0;
                            end
                        end else begin
                            comma_cnt_d = '0;
                            state_d     = SEARCH;
                        end
                    end
                end
                LOCKED: begin
                    if (boundary) begin
                        data_out_d = sr_nxt;
                        word_stb_d = 1'b1;
                        if (hit) miss_cnt_d = '0;
                    end else if (hit) begin
                        miss_cnt_d = miss_inc;
                        // Losing phase abandons the word in flight; data_out keeps the last good word.
                        if (miss_inc >= UNLOCK_C) begin
                            state_d     = SEARCH;
                            bit_cnt_d   = '0;
                            comma_cnt_d = '0;
                            miss_cnt_d  = '0;
                        end
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk_8f) begin
        if (!reset_L) begin
            state_q     <= SEARCH;
            sr_q        <= '0;
            bit_cnt_q   <= '0;
            comma_cnt_q <= '0;
            miss_cnt_q  <= '0;
            data_out_q  <= '0;
            word_stb_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            bit_cnt_q   <= bit_cnt_d;
            comma_cnt_q <= comma_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            data_out_q  <= data_out_d;
            word_stb_q  <= word_stb_d;
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.word_stb   = word_stb_q;
    assign bus.data_valid = word_stb_q & (data_out_q != COMMA);
    assign bus.is_comma   = word_stb_q & (data_out_q == COMMA);
    assign bus.locked     = (state_q == LOCKED);
    assign bus.state      = state_q;
endmodule

// File: tb/tb_rx_align_ctrl.sv
// Bench for rx_align_ctrl: serial stimulus, expected words queued as bytes are sent,
// compared whenever the aligner strobes a word.
module tb_rx_align_ctrl;
    localparam logic [7:0] COMMA = 8'hBC;

    logic clk_8f = 1'b0;
    logic reset_L;
    rx_align_ctrl_if ifc();

    rx_align_ctrl dut (
        .clk_8f  (clk_8f),
        .reset_L (reset_L),
        .bus     (ifc.slave)
    );

    always #5 clk_8f = ~clk_8f;

    int         vec = 0;
    int         err = 0;
    int         cyc = 0;
    int         n_stb = 0;
    int         last_cyc = 0;
    bit         last_ok = 1'b0;
    bit         gap_chk = 1'b0;
    logic [7:0] exp_q[$];

    // One bit clock; any strobe produced by this edge is scored against the queue.
    task automatic tick(input logic b);
        logic [7:0] e;
        ifc.in = b;
        @(posedge clk_8f);
        #1;
        cyc++;
        if (ifc.word_stb === 1'b1) begin
            n_stb++;
            vec++;
            if (exp_q.size() == 0) begin
                err++;
                $display("FAIL unexpected_stb: got data_out=%h, want no strobe", ifc.data_out);
            end else begin
                e = exp_q.pop_front();
                if ({ifc.data_out, ifc.data_valid, ifc.is_comma} !== {e, e != COMMA, e == COMMA}) begin
                    err++;
                    $display("FAIL word: got %h v=%b c=%b, want %h v=%b c=%b", ifc.data_out,
                             ifc.data_valid, ifc.is_comma, e, e != COMMA, e == COMMA);
                end
            end
            if (gap_chk && last_ok) begin
                vec++;
                if (cyc - last_cyc !== 8) begin
                    err++;
                    $display("FAIL stb_gap: got %0d, want 8", cyc - last_cyc);
                end
            end
            last_cyc = cyc;
            last_ok  = 1'b1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit push);
        if (push) exp_q.push_back(b);
        for (int i = 7; i >= 0; i--) tick(b[i]);
    endtask

    task automatic clr();
        ifc.enable = 1'b0;
        tick(1'b0);
        ifc.enable = 1'b1;
    endtask

    task automatic do_lock(input int off);
        clr();
        for (int i = 0; i < off; i++) tick(1'b0);
        for (int i = 0; i < 4; i++) send_byte(COMMA, 1'b0);
    endtask

    task automatic test_reset();
        reset_L    = 1'b0;
        ifc.enable = 1'b1;
        for (int i = 0; i < 3; i++) tick(1'($urandom_range(0, 1)));
        vec++;
        if ({ifc.data_out, ifc.word_stb, ifc.data_valid, ifc.is_comma, ifc.locked, ifc.state} !== 14'd0) begin
            err++;
            $display("FAIL reset_outputs: got %h/%b/%b/%b/%b/%b, want all 0", ifc.data_out,
                     ifc.word_stb, ifc.data_valid, ifc.is_comma, ifc.locked, ifc.state);
        end
        reset_L = 1'b1;
        send_byte(8'h00, 1'b0);
        vec++;
        if (ifc.state !== 2'b00) begin
            err++;
            $display("FAIL reset_idle_state: got %b, want 00", ifc.state);
        end
    endtask

    task automatic test_lock();
        tick(1'b1); tick(1'b0); tick(1'b1);
        send_byte(COMMA, 1'b0);
        vec++;
        if (ifc.state !== 2'b01) begin
            err++;
            $display("FAIL lock_first_bc: got state %b, want 01", ifc.state);
        end
        send_byte(COMMA, 1'b0);
        send_byte(COMMA, 1'b0);
        vec++;
        if ({ifc.locked, ifc.state} !== 3'b001) begin
            err++;
            $display("FAIL lock_third_bc: got locked=%b state=%b, want 0/01", ifc.locked, ifc.state);
        end
        send_byte(COMMA, 1'b0);
        vec++;
        if ({ifc.locked, ifc.state} !== 3'b110) begin
            err++;
            $display("FAIL lock_fourth_bc: got locked=%b state=%b, want 1/10", ifc.locked, ifc.state);
        end
        send_byte(COMMA, 1'b1);
        send_byte(8'h5A, 1'b1);
        send_byte(8'hA5, 1'b1);
        vec++;
        if (exp_q.size() !== 0) begin
            err++;
            $display("FAIL lock_words_left: got %0d pending, want 0", exp_q.size());
        end
    endtask

    task automatic test_check_fail();
        int stb0;
        clr();
        stb0 = n_stb;
        tick(1'b0); tick(1'b1); tick(1'b1);
        send_byte(COMMA, 1'b0);
        send_byte(COMMA, 1'b0);
        vec++;
        if (ifc.state !== 2'b01) begin
            err++;
            $display("FAIL chk_two_bc: got state %b, want 01", ifc.state);
        end
        send_byte(8'h3C, 1'b0);
        vec++;
        if ({ifc.state, dut.comma_cnt_q} !== 5'd0) begin
            err++;
            $display("FAIL chk_drop: got state=%b comma_cnt=%0d, want 00/0", ifc.state, dut.comma_cnt_q);
        end
        vec++;
        if (n_stb !== stb0) begin
            err++;
            $display("FAIL chk_no_stb: got %0d strobes, want 0", n_stb - stb0);
        end
    endtask

    task automatic test_unlock();
        // 0x17,0x80 carries a comma 3 bits off the word phase.
        do_lock(0);
        for (int g = 0; g < 2; g++) begin
            send_byte(8'h17, 1'b1); send_byte(8'h80, 1'b1); send_byte(8'h5A, 1'b1);
        end
        vec++;
        if (ifc.locked !== 1'b1) begin
            err++;
            $display("FAIL unlock_two_miss: got locked=%b, want 1", ifc.locked);
        end
        send_byte(8'h17, 1'b1);
        send_byte(8'h80, 1'b0);
        vec++;
        if ({ifc.locked, ifc.state, ifc.data_out} !== {1'b0, 2'b00, 8'h17}) begin
            err++;
            $display("FAIL unlock_third_miss: got locked=%b state=%b data=%h, want 0/00/17",
                     ifc.locked, ifc.state, ifc.data_out);
        end

        do_lock(0);
        for (int g = 0; g < 3; g++) begin
            send_byte(8'h17, 1'b1); send_byte(8'h80, 1'b1); send_byte(8'h5A, 1'b1);
            if (g == 1) send_byte(COMMA, 1'b1);
        end
        vec++;
        if (ifc.locked !== 1'b1 || exp_q.size() !== 0) begin
            err++;
            $display("FAIL unlock_aligned_bc: got locked=%b pending=%0d, want 1/0", ifc.locked, exp_q.size());
        end
    endtask

    task automatic test_midop_clear();
        for (int k = 0; k < 2; k++) begin
            do_lock(0);
            send_byte(8'h5A, 1'b1);
            tick(1'b1); tick(1'b0); tick(1'b1);
            if (k == 0) ifc.enable = 1'b0;
            else        reset_L    = 1'b0;
            tick(1'b1);
            ifc.enable = 1'b1;
            reset_L    = 1'b1;
            vec++;
            if ({ifc.data_out, ifc.word_stb, ifc.data_valid, ifc.is_comma, ifc.locked, ifc.state} !== 14'd0) begin
                err++;
                $display("FAIL midop_clear%0d: got %h/%b/%b/%b/%b/%b, want all 0", k, ifc.data_out,
                         ifc.word_stb, ifc.data_valid, ifc.is_comma, ifc.locked, ifc.state);
            end
            for (int i = 0; i < 3; i++) send_byte(COMMA, 1'b0);
            vec++;
            if (ifc.locked !== 1'b0) begin
                err++;
                $display("FAIL midop_three_bc%0d: got locked=%b, want 0", k, ifc.locked);
            end
            send_byte(COMMA, 1'b0);
            send_byte(8'hA5, 1'b1);
            vec++;
            if (ifc.locked !== 1'b1 || exp_q.size() !== 0) begin
                err++;
                $display("FAIL midop_relock%0d: got locked=%b pending=%0d, want 1/0", k, ifc.locked, exp_q.size());
            end
        end
    endtask

    task automatic test_sweep();
        logic [7:0] b;
        int         stb0;
        for (int off = 0; off < 8; off++) begin
            do_lock(off);
            vec++;
            if (ifc.locked !== 1'b1) begin
                err++;
                $display("FAIL sweep_lock off=%0d: got locked=%b, want 1", off, ifc.locked);
            end
            stb0    = n_stb;
            gap_chk = 1'b1;
            last_ok = 1'b0;
            // Bits 4 and 0 cleared: no run of four ones, so no stray comma in the stream.
            for (int i = 0; i < 16; i++) begin
                b = 8'($urandom) & 8'hEE;
                send_byte(b, 1'b1);
            end
            gap_chk = 1'b0;
            vec++;
            if (n_stb - stb0 !== 16 || exp_q.size() !== 0) begin
                err++;
                $display("FAIL sweep_count off=%0d: got %0d strobes pending=%0d, want 16/0",
                         off, n_stb - stb0, exp_q.size());
            end
        end
    endtask

    initial begin
        ifc.in     = 1'b0;
        ifc.enable = 1'b1;
        reset_L    = 1'b0;
        test_reset();
        test_lock();
        test_check_fail();
        test_unlock();
        test_midop_clear();
        test_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
